uart_buffered: RTL and testbench
================================

Name: uart_buffered

Overview:
- Parametrised successor to the single-byte UART manager.
- Adds independent RX and TX byte FIFOs and 1/2/4-byte little-endian word transfers on the core side.
- Reports FIFO occupancy, plus sticky overrun and framing-error flags.
- Sits between the core's I/O unit (order/accepted/done handshake) and the board rxd/txd pins; 8N1 framing.

Parameters:
- CLK_PER_BIT, `CLK_PER_BIT_DEFAULT (derived from `DEFAULT_BAUD): clock cycles per UART bit, >=16.
- RX_DEPTH, 16: RX FIFO entries; power of two, >=4.
- RX_ADDR, 4: log2(RX_DEPTH).
- TX_DEPTH, 16: TX FIFO entries; power of two, >=4.
- TX_ADDR, 4: log2(TX_DEPTH).

Ports:
- clk  in  1  system clock, single clock domain.
- rstn  in  1  asynchronous active-low reset.
- order  in  1  core request, held until accepted.
- accepted  out  1  one-cycle pulse: request latched.
- done  out  1  one-cycle pulse: request complete.
- size  in  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=4 bytes.
- write_flag  in  1  1=transmit write_data, 0=receive into read_data.
- write_data  in  32  bytes sent LSB first.
- read_data  out  32  received word, zero-extended.
- err_clear  in  1  clears overrun and frame_err.
- rx_count  out  RX_ADDR+1  RX FIFO occupancy.
- tx_count  out  TX_ADDR+1  TX FIFO occupancy.
- overrun  out  1  sticky: RX byte dropped because the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled 0.
- rxd  in  1  serial input, asynchronous to clk.
- txd  out  1  serial output, idles high.

Behaviour:
- Reset (rstn low, asynchronous): all outputs go to reset values immediately.
  - txd=1; accepted=done=0; read_data=0; counts=0; overrun=frame_err=0.
  - Both FIFOs empty; all FSMs in IDLE.
  - Reset mid-frame aborts the frame; no partial byte is retained.
- Core FSM states: IDLE, WR, RD, FIN.
- IDLE:
  - order=1 -> accepted=1 for that cycle.
  - Latches size, write_flag and write_data; clears byte index k and the assembly register.
  - Goes to WR if write_flag=1, otherwise RD.
- WR:
  - Each cycle the TX FIFO is not full, pushes byte k (write_data[8k+7:8k]) and increments k.
  - When the last byte is pushed -> FIN.
  - Stalls with no timeout while the FIFO is full.
- RD:
  - Each cycle the RX FIFO is not empty, pops a byte into assembly bits [8k+7:8k] and increments k.
  - When the last byte is popped -> FIN.
  - Stalls indefinitely while the FIFO is empty.
- FIN: done=1 for one cycle -> IDLE.
  - For reads, read_data updates on the same edge done rises and holds until the next read completes.
- Latency:
  - order to accepted = 1 cycle.
  - Write with free FIFO space: accepted to done = N+1 cycles (N = byte count).
  - Read with bytes already buffered: same as write.
- A new order is sampled only in IDLE; order held high through done starts a new transaction on the following cycle.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - Falling edge in idle starts a frame; start bit is rechecked at CLK_PER_BIT/2; if high it is a glitch -> idle.
  - Data bits are sampled every CLK_PER_BIT after that, LSB first, then the stop bit.
  - Stop=1 and FIFO not full -> byte pushed.
  - Stop=1 and FIFO full -> byte dropped, overrun set.
  - Stop=0 -> byte dropped, frame_err set.
  - Receiver returns to idle once the stop sample is taken.
- TX path:
  - When idle and the TX FIFO is non-empty, pops one byte.
  - Drives start bit, 8 data bits LSB first, then stop bit, each exactly CLK_PER_BIT cycles.
  - Checks the FIFO again immediately after the stop bit, giving back-to-back frames with no gap.
- FIFOs:
  - Pointers are RX_ADDR/TX_ADDR bits and wrap modulo depth; count is one bit wider so full (count=DEPTH) is distinguishable from empty.
  - Simultaneous push and pop: count unchanged, both take effect; allowed even when full (pop first) or empty (push only).
  - Push when full: ignored. Pop when empty: ignored.
- Flags:
  - err_clear has priority over a same-cycle set event, so the flag reads 0 after that cycle.
  - Flags never affect data flow.

Decomposition:
- include.vh:
  - `CLK_PER_BIT_DEFAULT, derived from `DEFAULT_BAUD and the clock frequency macro.
  - Size encodings `UART_SZ_B/H/W.
  - Core FSM state constants.
- Sub-module uart_byte_fifo: parameters DEPTH and ADDR; ports clk, rstn, push, din, pop, dout, count, full, empty.
  - Instantiated twice, for RX and TX.
  - dout is combinational from the head entry (first-word fall-through).
- RX and TX shifters stay inline.

Test Plan:
- Reset: pulse rstn low mid-TX-frame -> txd=1 within the same cycle; tx_count=0; no further edges on txd.
- Word write: size=2, write_data=0xA1B2C3D4 -> accepted, then done 5 cycles later; txd emits frames D4, C3, B2, A1 back-to-back with each bit exactly CLK_PER_BIT cycles.
- Half read: drive frames 0x34, 0x12 on rxd, then order size=1, read -> read_data=0x00001234 at done; rx_count back to 0.
- Read stall: order size=0 read with RX empty -> accepted only, no done; byte 0x5A arrives -> done within 3 cycles of the stop sample, read_data=0x0000005A.
- Overrun and wrap: send RX_DEPTH+1 bytes 0x00..0x10 without reading -> rx_count=16, overrun=1; reading 16 bytes returns 0x00..0x0F in order; err_clear -> overrun=0.
- Framing and glitch: frame with stop=0 -> frame_err=1, rx_count unchanged; a rxd low pulse shorter than CLK_PER_BIT/2 -> no byte pushed.

Source files
------------

// File: rtl/uart_buffered_pkg.sv
// Shared definitions for uart_buffered: default bit timing, core transfer
// size encodings, FSM state types, the latched core request and a helper
// mapping a size code to the index of its last byte.
package uart_buffered_pkg;

  localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
  localparam int unsigned DEFAULT_BAUD        = 115_200;
  localparam int unsigned CLK_PER_BIT_DEFAULT = CLK_FREQ_HZ / DEFAULT_BAUD;

  // Core transfer sizes; code 3 behaves like a word.
  localparam logic [1:0] UART_SZ_B = 2'd0;
  localparam logic [1:0] UART_SZ_H = 2'd1;
  localparam logic [1:0] UART_SZ_W = 2'd2;

  typedef enum logic [1:0] {CORE_IDLE, CORE_WR, CORE_RD, CORE_FIN} core_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP}   rx_state_e;
  typedef enum logic       {TX_IDLE, TX_SEND}                      tx_state_e;

  typedef struct packed {
    logic [1:0]  size;
    logic        wr;
    logic [31:0] data;
  } core_req_t;

  function automatic logic [1:0] last_byte_idx(input logic [1:0] sz);
    case (sz)
      UART_SZ_B: return 2'd0;
      UART_SZ_H: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word fall-through output.
// Ports:
//   clk, rstn      clock, async active-low reset
//   push, din      write strobe / data (ignored when full unless popping)
//   pop, dout      read strobe / head entry (combinational)
//   count          occupancy, ADDR+1 bits so full and empty differ
//   full, empty    status
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [ADDR:0] count,
  output logic          full,
  output logic          empty
);

  localparam int CW = ADDR + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR-1:0] wptr_q, rptr_q;
  logic [ADDR:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  // A pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push when it is also being popped.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_buffered.sv
// Buffered 8N1 UART between the core I/O unit and the board pins.
// Core side moves 1/2/4-byte little-endian words through RX/TX byte FIFOs
// using an order/accepted/done handshake.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   order, accepted, done         core handshake (pulses are one cycle)
//   size, write_flag, write_data  request: byte count code, direction, data
//   read_data                     last completed read, zero-extended
//   err_clear                     clears the sticky flags
//   rx_count, tx_count            FIFO occupancy
//   overrun, frame_err            sticky receive error flags
//   rxd, txd                      serial pins (txd idles high)
module uart_buffered
  import uart_buffered_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int RX_DEPTH    = 16,
  parameter int RX_ADDR     = 4,
  parameter int TX_DEPTH    = 16,
  parameter int TX_ADDR     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             order,
  output logic             accepted,
  output logic             done,
  input  logic [1:0]       size,
  input  logic             write_flag,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic             err_clear,
  output logic [RX_ADDR:0] rx_count,
  output logic [TX_ADDR:0] tx_count,
  output logic             overrun,
  output logic             frame_err,
  input  logic             rxd,
  output logic             txd
);

  localparam int                CNT_W    = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

  // ---------------- FIFOs ----------------
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_din, rx_dout;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_din, tx_dout;

  uart_byte_fifo #(.DEPTH(RX_DEPTH), .ADDR(RX_ADDR)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .din(rx_din), .pop(rx_pop),
    .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  uart_byte_fifo #(.DEPTH(TX_DEPTH), .ADDR(TX_ADDR)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .din(tx_din), .pop(tx_pop),
    .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- Core FSM ----------------
  core_state_e state_q;
  core_req_t   req_q;
  logic [1:0]  k_q;
  logic [31:0] asm_q;
  logic [1:0]  last_k;

  assign last_k  = last_byte_idx(req_q.size);
  assign tx_push = (state_q == CORE_WR) && !tx_full;
  assign tx_din  = req_q.data[{k_q, 3'b000} +: 8];
  assign rx_pop  = (state_q == CORE_RD) && !rx_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= CORE_IDLE;
      req_q     <= '0;
      k_q       <= '0;
      asm_q     <= '0;
      accepted  <= 1'b0;
      done      <= 1'b0;
      read_data <= '0;
    end else begin
      accepted <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        CORE_IDLE: if (order) begin
          accepted <= 1'b1;
          req_q    <= '{size: size, wr: write_flag, data: write_data};
          k_q      <= '0;
          asm_q    <= '0;
          state_q  <= write_flag ? CORE_WR : CORE_RD;
        end
        CORE_WR: if (!tx_full) begin
          k_q <= k_q + 1'b1;
          if (k_q == last_k) state_q <= CORE_FIN;
        end
        CORE_RD: if (!rx_empty) begin
          asm_q[{k_q, 3'b000} +: 8] <= rx_dout;
          k_q <= k_q + 1'b1;
          if (k_q == last_k) state_q <= CORE_FIN;
        end
        default: begin
          done <= 1'b1;
          if (!req_q.wr) read_data <= asm_q;
          state_q <= CORE_IDLE;
        end
      endcase
    end
  end

  // ---------------- Receiver ----------------
  rx_state_e        rx_state_q;
  logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             rx_stop_tick;

  assign rx_stop_tick = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST);
  assign rx_push      = rx_stop_tick && rxd_s2_q;
  assign rx_din       = rx_sh_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      case (rx_state_q)
        RX_IDLE: if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_q <= RX_START;
          rx_cnt_q   <= '0;
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // Line back high at mid start bit: treat it as a glitch.
            rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rxd_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_cnt_q == CNT_LAST) rx_state_q <= RX_IDLE;
          else                      rx_cnt_q   <= rx_cnt_q + 1'b1;
        end
      endcase
    end
  end

  // ---------------- Sticky flags ----------------
  logic ovr_set, fe_set;
  // A same-cycle core pop makes room, so that byte is not lost.
  assign ovr_set = rx_stop_tick && rxd_s2_q && rx_full && !rx_pop;
  assign fe_set  = rx_stop_tick && !rxd_s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (err_clear)    overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      if (err_clear)    frame_err <= 1'b0;
      else if (fe_set)  frame_err <= 1'b1;
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;   // 0 start, 1..8 data, 9 stop
  logic [8:0]       tx_sh_q;    // remaining data bits plus stop bit
  logic             txd_q;
  logic             tx_frame_end, tx_load;

  assign tx_frame_end = (tx_state_q == TX_SEND) && (tx_cnt_q == CNT_LAST) &&
                        (tx_bit_q == 4'd9);
  // Reloading at the end of the stop bit gives gapless back-to-back frames.
  assign tx_load = !tx_empty && ((tx_state_q == TX_IDLE) || tx_frame_end);
  assign tx_pop  = tx_load;
  assign txd     = txd_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '1;
      txd_q      <= 1'b1;
    end else if (tx_load) begin
      tx_state_q <= TX_SEND;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= {1'b1, tx_dout};
      txd_q      <= 1'b0;
    end else if (tx_frame_end) begin
      tx_state_q <= TX_IDLE;
      txd_q      <= 1'b1;
    end else if (tx_state_q == TX_SEND) begin
      if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_q <= '0;
        tx_bit_q <= tx_bit_q + 1'b1;
        txd_q    <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
module tb_uart_buffered;

  localparam int CPB = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        order = 1'b0, write_flag = 1'b0, err_clear = 1'b0, rxd = 1'b1;
  logic [1:0]  size = 2'd0;
  logic [31:0] write_data = '0;
  logic        accepted, done, overrun, frame_err, txd;
  logic [31:0] read_data;
  logic [4:0]  rx_count, tx_count;

  uart_buffered #(.CLK_PER_BIT(CPB), .RX_DEPTH(16), .RX_ADDR(4),
                  .TX_DEPTH(16), .TX_ADDR(4)) dut (
    .clk(clk), .rstn(rstn), .order(order), .accepted(accepted), .done(done),
    .size(size), .write_flag(write_flag), .write_data(write_data),
    .read_data(read_data), .err_clear(err_clear), .rx_count(rx_count),
    .tx_count(tx_count), .overrun(overrun), .frame_err(frame_err),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model state ----------------
  logic [7:0] rxm[$];       // bytes the receiver should hold
  logic [7:0] exp_tx[$];    // bytes expected on txd, in order
  logic [7:0] tx_got[$];    // bytes decoded from txd
  int         tx_starts[$]; // cycle of each decoded frame's falling edge
  bit         ovr_exp = 0, fe_exp = 0;
  bit         mon_en = 1;
  int         stop_cyc = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input bit stopbit);
    if (!stopbit) fe_exp = 1;
    else if (rxm.size() < RXD) rxm.push_back(b);
    else ovr_exp = 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sz);
    logic [31:0] w = '0;
    for (int i = 0; i < nbytes(sz); i++)
      if (rxm.size() > 0) w[8*i +: 8] = rxm.pop_front();
    return w;
  endfunction

  // ---------------- txd frame decoder ----------------
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rstn && prev && !txd) begin
        tx_starts.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        chk("tx_start_bit", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", {31'd0, txd}, 32'd1);
        tx_got.push_back(b);
      end
      prev = txd;
    end
  end

  // ---------------- Drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit stopbit);
    @(negedge clk); rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stopbit; stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic xfer(input bit wr, input logic [1:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int acc_lat, output int done_lat);
    @(negedge clk);
    order = 1'b1; write_flag = wr; size = sz; write_data = wd;
    acc_lat = 0;
    do begin @(negedge clk); acc_lat++; end while (!accepted && acc_lat < 2000);
    order = 1'b0;
    rd = '0; done_lat = -1;
    if (!accepted) begin chk("accept_timeout", 32'd0, 32'd1); return; end
    done_lat = 0;
    do begin @(negedge clk); done_lat++; end while (!done && done_lat < 20000);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    rd = read_data;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_got.size() < n && t < n * 12 * CPB + 1000) begin
      @(negedge clk); t++;
    end
    chk("tx_frames_seen", tx_got.size(), n);
  endtask

  task automatic cmp_tx();
    while (exp_tx.size() > 0) begin
      if (tx_got.size() == 0) begin
        chk("tx_byte_missing", 32'd0, {24'd0, exp_tx.pop_front()});
      end else begin
        chk("tx_byte", {24'd0, tx_got.pop_front()}, {24'd0, exp_tx.pop_front()});
      end
    end
  endtask

  // ---------------- Watchdog ----------------
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  // ---------------- Main sequence ----------------
  logic [31:0] rd, wd, exp;
  int          al, dl, dc, edges, rem;
  logic [1:0]  sz;
  logic        tprev;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_accepted", {31'd0, accepted}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_rx_count", {27'd0, rx_count}, 32'd0);
    chk("rst_tx_count", {27'd0, tx_count}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Word write: latency and gapless frames
    xfer(1'b1, 2'd2, 32'hA1B2C3D4, rd, al, dl);
    chk("wr_acc_lat", al, 32'd1);
    chk("wr_done_lat", dl, 32'd5);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'(32'hA1B2C3D4 >> (8*i)));
    wait_tx(4);
    for (int i = 1; i < 4 && i < tx_starts.size(); i++)
      chk("tx_frame_gap", tx_starts[i] - tx_starts[i-1], 10 * CPB);
    cmp_tx();
    tx_starts.delete();

    // Random writes of mixed sizes
    for (int n = 0; n < 6; n++) begin
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      xfer(1'b1, sz, wd, rd, al, dl);
      for (int i = 0; i < nbytes(sz); i++) exp_tx.push_back(wd[8*i +: 8]);
    end
    wait_tx(exp_tx.size());
    cmp_tx();

    // Half read of two buffered bytes
    send_byte(8'h34, 1'b1); model_rx(8'h34, 1'b1);
    send_byte(8'h12, 1'b1); model_rx(8'h12, 1'b1);
    chk("half_rx_count", {27'd0, rx_count}, rxm.size());
    xfer(1'b0, 2'd1, 32'd0, rd, al, dl);
    exp = model_read(2'd1);
    chk("half_read_data", rd, exp);
    chk("half_done_lat", dl, 32'd3);
    chk("half_rx_count_after", {27'd0, rx_count}, 32'd0);

    // Read stall: order with empty RX FIFO, byte arrives later
    @(negedge clk); order = 1'b1; write_flag = 1'b0; size = 2'd0;
    al = 0;
    do begin @(negedge clk); al++; end while (!accepted && al < 100);
    order = 1'b0;
    chk("stall_accepted", {31'd0, accepted}, 32'd1);
    dc = -1; rd = '0;
    fork
      send_byte(8'h5A, 1'b1);
      begin
        for (int i = 0; i < 14 * CPB; i++) begin
          @(negedge clk);
          if (done && dc < 0) begin dc = cyc; rd = read_data; end
        end
      end
    join
    model_rx(8'h5A, 1'b1);
    exp = model_read(2'd0);
    chk("stall_done_seen", {31'd0, dc >= 0}, 32'd1);
    chk("stall_done_after_stop", {31'd0, dc > stop_cyc}, 32'd1);
    chk("stall_done_prompt", {31'd0, dc <= stop_cyc + CPB + 3}, 32'd1);
    chk("stall_read_data", rd, exp);

    // Overrun and pointer wrap
    for (int b = 0; b <= RXD; b++) begin
      send_byte(8'(b), 1'b1);
      model_rx(8'(b), 1'b1);
    end
    chk("ovr_rx_count", {27'd0, rx_count}, rxm.size());
    chk("ovr_flag", {31'd0, overrun}, {31'd0, ovr_exp});
    while (rxm.size() > 0) begin
      rem = rxm.size();
      sz = (rem >= 4) ? 2'($urandom_range(0, 3)) : (rem >= 2) ? 2'($urandom_range(0, 1)) : 2'd0;
      xfer(1'b0, sz, 32'd0, rd, al, dl);
      exp = model_read(sz);
      chk("wrap_read_data", rd, exp);
      chk("wrap_rx_count", {27'd0, rx_count}, rxm.size());
    end
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0; ovr_exp = 0;
    chk("ovr_cleared", {31'd0, overrun}, {31'd0, ovr_exp});

    // Framing error and start-bit glitch
    send_byte(8'hC3, 1'b0); model_rx(8'hC3, 1'b0);
    chk("fe_flag", {31'd0, frame_err}, {31'd0, fe_exp});
    chk("fe_rx_count", {27'd0, rx_count}, rxm.size());
    @(negedge clk); rxd = 1'b0;
    repeat (CPB/2 - 3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_rx_count", {27'd0, rx_count}, rxm.size());
    wd = $urandom;
    send_byte(wd[7:0], 1'b1); model_rx(wd[7:0], 1'b1);
    xfer(1'b0, 2'd0, 32'd0, rd, al, dl);
    exp = model_read(2'd0);
    chk("post_glitch_read", rd, exp);
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0; fe_exp = 0;
    chk("fe_cleared", {31'd0, frame_err}, {31'd0, fe_exp});

    // Reset in the middle of a TX frame
    tx_got.delete(); tx_starts.delete();
    xfer(1'b1, 2'd2, $urandom, rd, al, dl);
    al = 0;
    while (tx_starts.size() == 0 && al < 1000) begin @(negedge clk); al++; end
    chk("midtx_frame_started", tx_starts.size(), 32'd1);
    mon_en = 0;
    repeat (3 * CPB) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midtx_rst_txd", {31'd0, txd}, 32'd1);
    chk("midtx_rst_tx_count", {27'd0, tx_count}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    edges = 0; tprev = txd;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (txd !== tprev) edges++;
      tprev = txd;
    end
    chk("midtx_no_txd_edges", edges, 32'd0);
    chk("midtx_tx_count_after", {27'd0, tx_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
